// File: rtl/uart_sid_bridge_n.sv
// UART-to-SID register bridge: 8N1 byte pairs (address, data) become one-cycle
// write strobes to one of NUM_SIDS SID cores, or to all of them on broadcast.
//
// receiver state | meaning
// RX_IDLE        | line idle, waiting for a falling edge
// RX_START       | half a bit into the start bit, confirming it is real
// RX_DATA        | sampling 8 data bits LSB first at mid-bit
// RX_STOP        | sampling the stop bit
// RX_BREAK       | stop bit was low; waiting for the line to return high
//
// pair state     | meaning
// PAIR_WAIT_ADDR | no address held
// PAIR_WAIT_DATA | address byte latched, waiting for its data byte

module uart_sid_bridge_n #(
   parameter int CLKS_PER_BIT = 1248,
   parameter int NUM_SIDS     = 2,
   parameter int MAX_REG      = 28,
   parameter int TIMEOUT_CLKS = 24960,
   parameter bit BROADCAST_EN = 1'b1
) (
   input  logic                CLK_IN,
   input  logic                RST_i,
   input  logic                RS232_RX_i,
   output logic [NUM_SIDS-1:0] SID_WE_o,
   output logic [4:0]          SID_ADDR_o,
   output logic [7:0]          SID_DATA_o,
   output logic                PENDING_o,
   output logic                FRAME_ERR_o,
   output logic                DROP_o
);

   localparam int CNT_MAX = (CLKS_PER_BIT > TIMEOUT_CLKS) ? CLKS_PER_BIT : TIMEOUT_CLKS;
   localparam int CW      = $clog2(CNT_MAX) + 1;

   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT_CLKS);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   typedef enum logic {
      PAIR_WAIT_ADDR,
      PAIR_WAIT_DATA
   } pair_state_e;

   logic                rx_meta_q, rx_meta_d;
   logic                rx_sync_q, rx_sync_d;
   rx_state_e           rx_state_q, rx_state_d;
   logic [CW-1:0]       baud_cnt_q, baud_cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          shift_q, shift_d;
   pair_state_e         pair_state_q, pair_state_d;
   logic [2:0]          chip_q, chip_d;
   logic [4:0]          reg_q, reg_d;
   logic [CW-1:0]       to_cnt_q, to_cnt_d;
   logic [NUM_SIDS-1:0] we_q, we_d;
   logic [4:0]          addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic                pending_q, pending_d;
   logic                frame_err_q, frame_err_d;
   logic                drop_q, drop_d;

   logic byte_valid;
   logic is_bcast;
   logic is_single;
   logic pair_ok;

   assign is_bcast  = BROADCAST_EN && (chip_q == 3'd7);
   assign is_single = int'(chip_q) < NUM_SIDS;
   assign pair_ok   = (int'(reg_q) <= MAX_REG) && (is_bcast || is_single);

   always_comb begin
      rx_meta_d    = RS232_RX_i;
      rx_sync_d    = rx_meta_q;
      rx_state_d   = rx_state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      pair_state_d = pair_state_q;
      chip_d       = chip_q;
      reg_d        = reg_q;
      to_cnt_d     = to_cnt_q;
      we_d         = '0;
      addr_d       = addr_q;
      data_d       = data_q;
      frame_err_d  = 1'b0;
      drop_d       = 1'b0;
      byte_valid   = 1'b0;

      unique case (rx_state_q)
         RX_IDLE: begin
            if (!rx_sync_q) begin
               rx_state_d = RX_START;
               baud_cnt_d = HALF_LOAD;
            end
         end
         RX_START: begin
            if (baud_cnt_q == '0) begin
               if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  baud_cnt_d = BIT_LOAD;
                  bit_idx_d  = 3'd0;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - CW'(1);
            end
         end
         RX_DATA: begin
            if (baud_cnt_q == '0) begin
               shift_d    = {rx_sync_q, shift_q[7:1]};
               baud_cnt_d = BIT_LOAD;
               if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
               else                   bit_idx_d  = bit_idx_q + 3'd1;
            end else begin
               baud_cnt_d = baud_cnt_q - CW'(1);
            end
         end
         RX_STOP: begin
            if (baud_cnt_q == '0) begin
               if (rx_sync_q) begin
                  byte_valid = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  rx_state_d  = RX_BREAK;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - CW'(1);
            end
         end
         RX_BREAK: begin
            // a held-low line must not be mistaken for a fresh start bit
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase

      unique case (pair_state_q)
         PAIR_WAIT_ADDR: begin
            if (byte_valid) begin
               chip_d       = shift_q[7:5];
               reg_d        = shift_q[4:0];
               to_cnt_d     = '0;
               pair_state_d = PAIR_WAIT_DATA;
            end
         end
         PAIR_WAIT_DATA: begin
            if (byte_valid) begin
               pair_state_d = PAIR_WAIT_ADDR;
               if (pair_ok) begin
                  we_d   = is_bcast ? '1 : (NUM_SIDS'(1) << chip_q);
                  addr_d = reg_q;
                  data_d = shift_q;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (rx_state_q == RX_IDLE) begin
               to_cnt_d = to_cnt_q + CW'(1);
               if (to_cnt_d == TO_LIMIT) pair_state_d = PAIR_WAIT_ADDR;
            end
         end
         default: pair_state_d = PAIR_WAIT_ADDR;
      endcase

      if (frame_err_d) pair_state_d = PAIR_WAIT_ADDR;

      pending_d = (pair_state_d == PAIR_WAIT_DATA);
   end

   always_ff @(posedge CLK_IN or posedge RST_i) begin
      if (RST_i) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         baud_cnt_q   <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'd0;
         pair_state_q <= PAIR_WAIT_ADDR;
         chip_q       <= 3'd0;
         reg_q        <= 5'd0;
         to_cnt_q     <= '0;
         we_q         <= '0;
         addr_q       <= 5'd0;
         data_q       <= 8'd0;
         pending_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_sync_q    <= rx_sync_d;
         rx_state_q   <= rx_state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         pair_state_q <= pair_state_d;
         chip_q       <= chip_d;
         reg_q        <= reg_d;
         to_cnt_q     <= to_cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         pending_q    <= pending_d;
         frame_err_q  <= frame_err_d;
         drop_q       <= drop_d;
      end
   end

   assign SID_WE_o    = we_q;
   assign SID_ADDR_o  = addr_q;
   assign SID_DATA_o  = data_q;
   assign PENDING_o   = pending_q;
   assign FRAME_ERR_o = frame_err_q;
   assign DROP_o      = drop_q;

endmodule
